axi_arbiter_s2m_s3: RTL and testbench

Response-direction arbiter for the AXI interconnect. It grants one of NUM slaves at a time to return R (read data) and B (write response) beats to a single master port. This is the mirror of the master-to-slave AW/W/AR arbiter. It sits per master port, ahead of the R/B return muxes, which are steered by RGRANT and BGRANT. The R grant is locked for a whole burst, through the RLAST beat. The B grant is locked for a single response beat.

---
 rtl/axi_arbiter_s2m_s3.sv | 168 ++++++++++++++++
 tb/tb_axi_arbiter_s2m_s3.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_arbiter_s2m_s3.sv
// Slave-to-master R/B round-robin arbiter for one AXI master port; R locks per burst, B per beat.
// Optional R beat counter with overrun release: define AXI_S2M_BEAT_CNT_EN.
module axi_arbiter_s2m_s3 #(
  parameter int NUM   = 3,
  parameter int W_CID = 4,
  parameter int W_ID  = 4
) (
  input  logic           AXI_CLK,
  input  logic           AXI_RST,
  input  logic [NUM-1:0] RSELECT,
  input  logic [NUM-1:0] RVALID,
  input  logic [NUM-1:0] RLAST,
  input  logic           RREADY,
  output logic [NUM-1:0] RGRANT,
`ifdef AXI_S2M_BEAT_CNT_EN
  output logic [8:0]     R_BEATS,
  output logic [0:0]     R_OVERRUN,
`endif
  input  logic [NUM-1:0] BSELECT,
  input  logic [NUM-1:0] BVALID,
  input  logic           BREADY,
  output logic [NUM-1:0] BGRANT
);

  localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [NUM-1:0] PTR_RST = NUM'(1) << (NUM - 1);

  // The ID widths only describe sideband that travels beside the grant untouched.
  if (W_CID < 1 || W_ID < 1) begin : g_bad_id_width
  end

  typedef enum logic {R_IDLE, R_BUSY} r_state_t;
  typedef enum logic {B_IDLE, B_BUSY} b_state_t;

  // Search starts just above the pointer and wraps; the pointer bit itself is tried last.
  function automatic logic [NUM-1:0] rr_pick(input logic [NUM-1:0] req,
                                             input logic [NUM-1:0] ptr);
    logic [NUM-1:0] gnt;
    logic           found;
    gnt   = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM; off++) begin
      for (int i = 0; i < NUM; i++) begin
        if (!found && ptr[IW'(i)] && req[IW'((i + off) % NUM)]) begin
          gnt[IW'((i + off) % NUM)] = 1'b1;
          found                     = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

  r_state_t       r_state, r_state_nxt;
  logic [NUM-1:0] r_lock, r_lock_nxt, r_ptr, r_ptr_nxt, r_pick, r_grant;
  logic           r_done, r_force_release;

  b_state_t       b_state, b_state_nxt;
  logic [NUM-1:0] b_lock, b_lock_nxt, b_ptr, b_ptr_nxt, b_pick, b_grant;
  logic           b_done;

  assign r_pick  = rr_pick(RSELECT & RVALID, r_ptr);
  assign r_grant = (r_state == R_IDLE) ? r_pick : r_lock;
  assign r_done  = RREADY && |(r_grant & RVALID & RLAST);
  assign RGRANT  = AXI_RST ? '0 : r_grant;

  assign b_pick  = rr_pick(BSELECT & BVALID, b_ptr);
  assign b_grant = (b_state == B_IDLE) ? b_pick : b_lock;
  assign b_done  = BREADY && |(b_grant & BVALID);
  assign BGRANT  = AXI_RST ? '0 : b_grant;

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    r_state_nxt = r_state;
    r_lock_nxt  = r_lock;
    r_ptr_nxt   = r_ptr;
    case (r_state)
      R_IDLE: begin
        if (|r_pick) begin
          r_ptr_nxt = r_pick;
          if (!r_done) begin
            r_lock_nxt  = r_pick;
            r_state_nxt = R_BUSY;
          end
        end
      end
      R_BUSY: begin
        if (r_done || r_force_release) begin
          r_lock_nxt  = '0;
          r_state_nxt = R_IDLE;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    b_state_nxt = b_state;
    b_lock_nxt  = b_lock;
    b_ptr_nxt   = b_ptr;
    case (b_state)
      B_IDLE: begin
        if (|b_pick) begin
          b_ptr_nxt = b_pick;
          if (!b_done) begin
            b_lock_nxt  = b_pick;
            b_state_nxt = B_BUSY;
          end
        end
      end
      B_BUSY: begin
        if (b_done) begin
          b_lock_nxt  = '0;
          b_state_nxt = B_IDLE;
        end
      end
      default: b_state_nxt = B_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge AXI_CLK or posedge AXI_RST) begin
    if (AXI_RST) begin
      r_state <= R_IDLE;
      r_lock  <= '0;
      r_ptr   <= PTR_RST;
      b_state <= B_IDLE;
      b_lock  <= '0;
      b_ptr   <= PTR_RST;
    end else begin
      r_state <= r_state_nxt;
      r_lock  <= r_lock_nxt;
      r_ptr   <= r_ptr_nxt;
      b_state <= b_state_nxt;
      b_lock  <= b_lock_nxt;
      b_ptr   <= b_ptr_nxt;
    end
  end

`ifdef AXI_S2M_BEAT_CNT_EN
  logic       r_beat;
  logic [8:0] r_beats;
  logic       r_overrun;

  // A 256th beat without RLAST frees the master from a slave that never ends its burst.
  assign r_beat          = RREADY && |(r_grant & RVALID);
  assign r_force_release = r_beat && !r_done && (r_beats == 9'd255);

  always_ff @(posedge AXI_CLK or posedge AXI_RST) begin
    if (AXI_RST) begin
      r_beats   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_force_release;
      if (r_done || r_force_release) begin
        r_beats <= '0;
      end else if (r_beat) begin
        r_beats <= r_beats + 9'd1;
      end
    end
  end

  assign R_BEATS   = r_beats;
  assign R_OVERRUN = r_overrun;
`else
  assign r_force_release = 1'b0;
`endif

endmodule

// File: tb/tb_axi_arbiter_s2m_s3.sv
// Directed bench for axi_arbiter_s2m_s3: integer-owner reference model compared every cycle,
// plus hand-computed grant expectations for each scenario.
module tb_axi_arbiter_s2m_s3;

  localparam int NUM = 3;

  logic           clk;
  logic           rst;
  logic [NUM-1:0] rsel, rvalid, rlast, rgrant;
  logic [NUM-1:0] bsel, bvalid, bgrant;
  logic           rready, bready;
`ifdef AXI_S2M_BEAT_CNT_EN
  logic [8:0]     r_beats;
  logic [0:0]     r_overrun;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  axi_arbiter_s2m_s3 #(.NUM(NUM), .W_CID(4), .W_ID(4)) dut (
    .AXI_CLK  (clk),
    .AXI_RST  (rst),
    .RSELECT  (rsel),
    .RVALID   (rvalid),
    .RLAST    (rlast),
    .RREADY   (rready),
    .RGRANT   (rgrant),
`ifdef AXI_S2M_BEAT_CNT_EN
    .R_BEATS  (r_beats),
    .R_OVERRUN(r_overrun),
`endif
    .BSELECT  (bsel),
    .BVALID   (bvalid),
    .BREADY   (bready),
    .BGRANT   (bgrant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model: owner index, last-granted index ----------------
  int   m_r_owner = -1, m_r_last = NUM - 1;
  int   m_b_owner = -1, m_b_last = NUM - 1;
  int   m_r_idx, m_b_idx;
  logic m_r_hs, m_r_fin, m_r_ovr_evt, m_b_hs;
`ifdef AXI_S2M_BEAT_CNT_EN
  int   m_beats = 0;
  logic m_ovr   = 1'b0;
`endif

  function automatic int rr_pick(input logic [NUM-1:0] req, input int last);
    for (int k = 1; k <= NUM; k++) begin
      if (req[(last + k) % NUM]) return (last + k) % NUM;
    end
    return -1;
  endfunction

  function automatic logic [NUM-1:0] onehot(input int idx);
    if (idx < 0) return '0;
    return NUM'(1) << idx;
  endfunction

  always_comb begin
    m_r_idx     = (m_r_owner >= 0) ? m_r_owner : rr_pick(rsel & rvalid, m_r_last);
    m_r_hs      = (m_r_idx >= 0) && rvalid[m_r_idx] && rready;
    m_r_fin     = m_r_hs && rlast[m_r_idx];
    m_r_ovr_evt = 1'b0;
`ifdef AXI_S2M_BEAT_CNT_EN
    m_r_ovr_evt = m_r_hs && !m_r_fin && (m_beats == 255);
`endif
    m_b_idx     = (m_b_owner >= 0) ? m_b_owner : rr_pick(bsel & bvalid, m_b_last);
    m_b_hs      = (m_b_idx >= 0) && bvalid[m_b_idx] && bready;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_r_owner <= -1;
      m_r_last  <= NUM - 1;
      m_b_owner <= -1;
      m_b_last  <= NUM - 1;
`ifdef AXI_S2M_BEAT_CNT_EN
      m_beats   <= 0;
      m_ovr     <= 1'b0;
`endif
    end else begin
      if (m_r_idx >= 0) begin
        if (m_r_owner < 0) m_r_last <= m_r_idx;
        m_r_owner <= (m_r_fin || m_r_ovr_evt) ? -1 : m_r_idx;
      end
      if (m_b_idx >= 0) begin
        if (m_b_owner < 0) m_b_last <= m_b_idx;
        m_b_owner <= m_b_hs ? -1 : m_b_idx;
      end
`ifdef AXI_S2M_BEAT_CNT_EN
      m_ovr <= m_r_ovr_evt;
      if (m_r_hs) m_beats <= (m_r_fin || m_r_ovr_evt) ? 0 : m_beats + 1;
`endif
    end
  end

  always @(negedge clk) begin
    check("rgrant_vs_model", rgrant, rst ? '0 : onehot(m_r_idx));
    check("bgrant_vs_model", bgrant, rst ? '0 : onehot(m_b_idx));
`ifdef AXI_S2M_BEAT_CNT_EN
    check("r_beats_vs_model", r_beats, m_beats);
    check("r_overrun_vs_model", r_overrun, m_ovr);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic r_cyc(input string name, input logic [NUM-1:0] exp_r);
    @(negedge clk);
    check(name, rgrant, exp_r);
    @(posedge clk);
    #1;
  endtask

  task automatic rb_cyc(input string name, input logic [NUM-1:0] exp_r, input logic [NUM-1:0] exp_b);
    @(negedge clk);
    check({name, "_r"}, rgrant, exp_r);
    check({name, "_b"}, bgrant, exp_b);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: summary not reached within 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rsel = 3'b111; rvalid = 3'b111; rlast = 3'b000; rready = 1'b1;
    bsel = 3'b101; bvalid = 3'b101; bready = 1'b0;

    // Requests present during reset must not leak through.
    @(negedge clk);
    check("reset_rgrant", rgrant, 3'b000);
    check("reset_bgrant", bgrant, 3'b000);
    @(posedge clk);
    #1;
    bsel = '0; bvalid = '0;
    rst  = 1'b0;

    // 1: round-robin order 001 -> 010 -> 100 -> 001; first burst is two beats.
    r_cyc("t1_first", 3'b001);
    rlast = 3'b111;
    r_cyc("t1_first_last", 3'b001);
    r_cyc("t1_rr_010", 3'b010);
    r_cyc("t1_rr_100", 3'b100);
    r_cyc("t1_wrap_001", 3'b001);
    rsel = '0; rvalid = '0; rlast = '0;
    r_cyc("t1_idle", 3'b000);

    // 2: slave1 4-beat burst, stall on beat 2, slave0 arrives mid-burst.
    rsel = 3'b010; rvalid = 3'b010;
    r_cyc("t2_beat1", 3'b010);
    rready = 1'b0;
    r_cyc("t2_stall", 3'b010);
    rready = 1'b1; rsel = 3'b011; rvalid = 3'b011;
    r_cyc("t2_beat2_newcomer", 3'b010);
    r_cyc("t2_beat3", 3'b010);
    rlast = 3'b010;
    r_cyc("t2_beat4_last", 3'b010);
    rsel = 3'b001; rvalid = 3'b001; rlast = 3'b001;
    r_cyc("t2_next_slave0", 3'b001);

    // 3: single-beat in IDLE keeps no lock; slave2 granted back-to-back.
    rsel = 3'b110; rvalid = 3'b110; rlast = 3'b010;
    r_cyc("t3_single_beat", 3'b010);
    rsel = 3'b100; rvalid = 3'b100; rlast = 3'b100;
    r_cyc("t3_back_to_back", 3'b100);
    rsel = '0; rvalid = '0; rlast = '0;
    r_cyc("t3_idle", 3'b000);

    // 4: B held on slave0 through 3 stalled cycles; R independently on slave2.
    rsel = 3'b100; rvalid = 3'b100;
    bsel = 3'b101; bvalid = 3'b101; bready = 1'b0;
    rb_cyc("t4_bstall1", 3'b100, 3'b001);
    rb_cyc("t4_bstall2", 3'b100, 3'b001);
    rb_cyc("t4_bstall3", 3'b100, 3'b001);
    bready = 1'b1;
    rb_cyc("t4_bhandshake", 3'b100, 3'b001);
    rb_cyc("t4_bnext", 3'b100, 3'b100);
    bsel = '0; bvalid = '0;
    rb_cyc("t4_bidle", 3'b100, 3'b000);

    // 5: asynchronous reset in the middle of slave2's R burst.
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_async_rgrant", rgrant, 3'b000);
    rsel = 3'b110; rvalid = 3'b110;
    @(posedge clk);
    #1;
    rst = 1'b0;
    r_cyc("t5_after_rst", 3'b010);
    rlast = 3'b110;
    r_cyc("t5_last", 3'b010);
    rsel = '0; rvalid = '0; rlast = '0;
    r_cyc("t5_idle", 3'b000);

`ifdef AXI_S2M_BEAT_CNT_EN
    // 6: slave0 streams 256 beats without RLAST; slave1 waits and takes over on release.
    rsel = 3'b001; rvalid = 3'b001;
    for (int i = 0; i < 255; i++) begin
      if (i == 200) begin
        rsel = 3'b011; rvalid = 3'b011;
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("t6_beats_255", r_beats, 9'd255);
    check("t6_no_overrun_yet", r_overrun, 1'b0);
    check("t6_still_slave0", rgrant, 3'b001);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t6_overrun_pulse", r_overrun, 1'b1);
    check("t6_beats_cleared", r_beats, 9'd0);
    check("t6_released_to_slave1", rgrant, 3'b010);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t6_overrun_one_cycle", r_overrun, 1'b0);
    check("t6_slave1_beat1", r_beats, 9'd1);
    @(posedge clk);
    #1;
    rsel = 3'b010; rvalid = 3'b010; rlast = 3'b010;
    r_cyc("t6_slave1_last", 3'b010);
    rsel = '0; rvalid = '0; rlast = '0;
    r_cyc("t6_idle", 3'b000);
`endif

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
